// File: rtl/uart_tx_core.sv
// UART transmit serializer: pops one byte per frame from a FWFT FIFO and emits start/data/[parity]/stop.
// Optional parity stage is enabled by defining UART_TX_PARITY_EN.
module uart_tx_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  tx_en_i,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  stop_bits_i,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
`endif
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rd_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
`endif
    logic                  start_c;
    logic                  bit_end_c;

    // Pop is gated by reset so a held reset never consumes a FIFO word
    assign start_c   = tx_en_i && !fifo_empty_i && rstn_i;
    assign bit_end_c = (cnt_q == div_q);
    assign fifo_rd_o = (state_q == IDLE) && start_c;

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        div_d     = div_q;
        cnt_d     = '0;
        bit_d     = bit_q;
        stop2_d   = stop2_q;
        done_d    = 1'b0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif

        if (state_q != IDLE && !bit_end_c) begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    shift_d   = fifo_rdata_i;
                    div_d     = baud_div_i;
                    stop2_d   = stop_bits_i;
                    bit_d     = '0;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = parity_en_i;
                    par_bit_d = (^fifo_rdata_i) ^ parity_odd_i;
`endif
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // bit_q counts stop bits already sent when two are requested
                if (bit_end_c) begin
                    if (stop2_q && bit_q == '0) begin
                        bit_d = BIT_W'(1);
                    end else begin
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || done_d;

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_bit_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: stimulus queues bytes plus expected frames, a monitor decodes tx_o.
// Parity vectors are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_core;

    logic        clk_i        = 1'b0;
    logic        rstn_i       = 1'b0;
    logic        tx_en_i      = 1'b0;
    logic [15:0] baud_div_i   = 16'd0;
    logic        stop_bits_i  = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic        parity_en_i  = 1'b0;
    logic        parity_odd_i = 1'b0;
`endif
    logic        fifo_empty_i;
    logic [7:0]  fifo_rdata_i;
    logic        fifo_rd_o;
    logic        tx_o;
    logic        busy_o;
    logic        frame_done_o;

    uart_tx_core #(
        .DATA_WIDTH(8),
        .DIV_WIDTH (16)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .tx_en_i     (tx_en_i),
        .baud_div_i  (baud_div_i),
        .stop_bits_i (stop_bits_i),
`ifdef UART_TX_PARITY_EN
        .parity_en_i (parity_en_i),
        .parity_odd_i(parity_odd_i),
`endif
        .fifo_empty_i(fifo_empty_i),
        .fifo_rdata_i(fifo_rdata_i),
        .fifo_rd_o   (fifo_rd_o),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    // FWFT FIFO model: stimulus owns the write side, this block owns the read pointer
    logic [7:0] fmem [32];
    logic [4:0] fwr = 5'd0;
    logic [4:0] frd = 5'd0;
    assign fifo_empty_i = (fwr == frd);
    assign fifo_rdata_i = fmem[frd];
    always @(posedge clk_i) if (fifo_rd_o && !fifo_empty_i) frd <= frd + 5'd1;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         stop2;
        bit         par_en;
        bit         par_bit;
        int         len;
        bit         b2b;
        bit         abort;
    } exp_t;

    exp_t exp_mem [32];
    int   exp_wr     = 0;
    int   exp_rd     = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   pops       = 0;
    int   cyc        = 0;
    int   last_done  = -100;
    bit   final_req  = 1'b0;
    bit   final_done = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // ---------------- monitor ----------------
    task automatic tick();
        @(negedge clk_i);
        if (fifo_rd_o === 1'b1) begin
            pops++;
            check("pop_legal", 32'({tx_en_i, fifo_empty_i, rstn_i}), 32'b101);
        end
    endtask

    task automatic run_frame();
        exp_t e;
        logic bits [16];
        int   nb;
        int   start_cyc;
        bit   aborted;
        bit   bit_ok;
        bit   ctl_ok;
        check("frame_expected", 32'(exp_wr != exp_rd), 32'd1);
        if (exp_wr == exp_rd) return;
        e = exp_mem[exp_rd];
        exp_rd++;
        start_cyc = cyc;
        if (e.b2b) check($sformatf("gap_before_%02h", e.data), 32'(start_cyc - last_done), 32'd1);

        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = e.data[i]; nb++;
        end
        if (e.par_en) begin
            bits[nb] = e.par_bit; nb++;
        end
        bits[nb] = 1'b1; nb++;
        if (e.stop2) begin
            bits[nb] = 1'b1; nb++;
        end

        aborted = 1'b0;
        ctl_ok  = 1'b1;
        for (int b = 0; b < nb && !aborted; b++) begin
            bit_ok = 1'b1;
            for (int k = 0; k <= e.div; k++) begin
                if (b != 0 || k != 0) begin
                    tick();
                    if (!rstn_i) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (tx_o !== bits[b]) bit_ok = 1'b0;
                if (busy_o !== 1'b1 || frame_done_o !== 1'b0) ctl_ok = 1'b0;
            end
            if (!aborted) check($sformatf("frame_%02h_bit%0d", e.data, b), 32'(bit_ok), 32'd1);
        end

        if (!aborted) begin
            tick();
            if (!rstn_i) aborted = 1'b1;
        end
        check($sformatf("abort_%02h", e.data), 32'(aborted), 32'(e.abort));
        if (aborted) begin
            check("reset_tx_busy", 32'({tx_o, busy_o}), 32'b10);
        end else begin
            check($sformatf("done_%02h", e.data), 32'({tx_o, busy_o, frame_done_o}), 32'b111);
            check($sformatf("len_%02h", e.data), 32'(cyc - start_cyc), 32'(e.len));
            check($sformatf("busy_in_frame_%02h", e.data), 32'(ctl_ok), 32'd1);
            last_done = cyc;
        end
    endtask

    initial begin : monitor
        forever begin
            tick();
            if (final_req && !final_done) begin
                check("pop_count", 32'(pops), 32'(exp_wr));
                final_done = 1'b1;
            end
            if (!rstn_i) begin
                check("reset_state", 32'({tx_o, busy_o, frame_done_o, fifo_rd_o}), 32'b1000);
            end else if (tx_o === 1'b0) begin
                run_frame();
            end else begin
                check("idle_quiet", 32'({busy_o, frame_done_o}), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int div, input bit s2, input bit pe, input bit pb,
                        input int len, input bit b2b, input bit ab);
        fmem[fwr] = d;
        fwr = fwr + 5'd1;
        exp_mem[exp_wr].data    = d;
        exp_mem[exp_wr].div     = div;
        exp_mem[exp_wr].stop2   = s2;
        exp_mem[exp_wr].par_en  = pe;
        exp_mem[exp_wr].par_bit = pb;
        exp_mem[exp_wr].len     = len;
        exp_mem[exp_wr].b2b     = b2b;
        exp_mem[exp_wr].abort   = ab;
        exp_wr++;
    endtask

    task automatic timeout(input string what);
        $display("FAIL timeout_%s: got no progress expected completion", what);
        $fatal(1, "bench stopped on timeout");
    endtask

    task automatic drain();
        int n = 0;
        do begin
            step();
            n++;
        end while (!(exp_rd == exp_wr && busy_o == 1'b0 && fifo_empty_i) && n < 3000);
        if (n >= 3000) timeout("drain");
    endtask

    task automatic wait_pop(input int p0);
        int n = 0;
        while (pops == p0 && n < 200) begin
            step();
            n++;
        end
        if (pops == p0) timeout("pop");
    endtask

    task automatic wait_done();
        int n = 0;
        while (frame_done_o !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) timeout("frame_done");
    endtask

    initial begin : stim
        int p0;
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i  = 1'b1;
        tx_en_i = 1'b1;
        step();

        // 0xA5, 4 clocks per bit, one stop bit: 10 bits * 4 = 40 clocks
        baud_div_i  = 16'd3;
        stop_bits_i = 1'b0;
        send(8'hA5, 3, 1'b0, 1'b0, 1'b0, 40, 1'b0, 1'b0);
        drain();

        // Back-to-back frames at 1 clock per bit, 1 idle clock between frames
        baud_div_i = 16'd0;
        send(8'h00, 0, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0);
        send(8'hFF, 0, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        send(8'h55, 0, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        drain();

        // Two stop bits latched; config changes mid-frame must be ignored: 11 bits * 2 = 22
        baud_div_i  = 16'd1;
        stop_bits_i = 1'b1;
        p0 = pops;
        send(8'h80, 1, 1'b1, 1'b0, 1'b0, 22, 1'b0, 1'b0);
        wait_pop(p0);
        stop_bits_i = 1'b0;
        baud_div_i  = 16'd5;
        drain();

        // Enable dropped during DATA: 0x3C completes, 0x11 waits for re-enable
        baud_div_i  = 16'd1;
        stop_bits_i = 1'b0;
        p0 = pops;
        send(8'h3C, 1, 1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0);
        send(8'h11, 1, 1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0);
        wait_pop(p0);
        repeat (6) step();
        tx_en_i = 1'b0;
        wait_done();
        repeat (10) step();
        tx_en_i = 1'b1;
        drain();

        // Reset during data bit 3 of 0x0F; 0xC3 must follow cleanly after release
        p0 = pops;
        send(8'h0F, 1, 1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b1);
        send(8'hC3, 1, 1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0);
        wait_pop(p0);
        repeat (8) step();
        rstn_i = 1'b0;
        repeat (3) step();
        rstn_i = 1'b1;
        drain();

`ifdef UART_TX_PARITY_EN
        baud_div_i   = 16'd0;
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b0;
        send(8'h07, 0, 1'b0, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        drain();
        parity_odd_i = 1'b1;
        send(8'h07, 0, 1'b0, 1'b1, 1'b0, 11, 1'b0, 1'b0);
        drain();
        parity_odd_i = 1'b0;
        send(8'h03, 0, 1'b0, 1'b1, 1'b0, 11, 1'b0, 1'b0);
        drain();
        parity_en_i = 1'b0;
        send(8'h07, 0, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0);
        drain();
`endif

        final_req = 1'b1;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
UART transmit serializer that drains the TX FIFO and drives the serial line.
- Pops one byte per frame from a first-word-fall-through FIFO.
- Emits start bit, LSB-first data, optional parity, and 1 or 2 stop bits.
- Bit period comes from a programmable clock divider.
- Sits between the TX-side uart_fifo read port and the top-level tx pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 legal).
DIV_WIDTH, 16, width of the baud divider input.

Ports:
clk_i  input  1  system clock
rstn_i  input  1  asynchronous active-low reset
tx_en_i  input  1  transmitter enable
baud_div_i  input  DIV_WIDTH  bit period = baud_div_i+1 clocks
stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits
fifo_empty_i  input  1  TX FIFO empty flag
fifo_rdata_i  input  DATA_WIDTH  FIFO head word, valid while !fifo_empty_i
fifo_rd_o  output  1  one-cycle pop strobe
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress
frame_done_o  output  1  one-cycle pulse after last stop bit

Behaviour:
- Interface: one clock (clk_i); reset rstn_i is asynchronous, active-low.
- Reset values: tx_o=1, busy_o=0, fifo_rd_o=0, frame_done_o=0, FSM=IDLE, counters=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Start condition: tx_en_i=1 and fifo_empty_i=0.
  - Actions: latch fifo_rdata_i into the shift register, latch baud_div_i and stop_bits_i, assert fifo_rd_o for exactly that cycle, go to START.
  - tx_o drops low on the next cycle.
  - Latency: 1 clock from !empty to the start-bit edge.
- Bit timing:
  - Divider counter counts 0..div_latched; each bit lasts div_latched+1 clocks.
  - baud_div_i=0 gives 1 clock per bit (legal).
  - Changes to baud_div_i or stop_bits_i mid-frame are ignored until the next frame.
- START: tx_o=0 for one bit period, then DATA.
- DATA:
  - tx_o = shift[0]; shift right at each bit end; bit counter runs 0..DATA_WIDTH-1.
  - After the last bit: PARITY if the parity feature is active, else STOP.
- PARITY: one bit period (see Optional Feature), then STOP.
- STOP:
  - tx_o=1 for 1 or 2 bit periods, per latched stop_bits.
  - On the final stop-bit end: pulse frame_done_o for 1 clock, return to IDLE.
- Back-to-back frames: if the FIFO is non-empty and tx_en_i=1 in the cycle after STOP ends, the next frame starts. Gap = exactly 1 clock of idle-high beyond the stop period.
- busy_o is 1 from the cycle after the pop through the frame_done_o cycle inclusive.
- tx_en_i deassert mid-frame: the current frame completes normally; no new pop while tx_en_i=0.
- fifo_empty_i rising mid-frame: no effect; the data is already latched.
- fifo_rd_o is never asserted while fifo_empty_i=1 and never asserted outside IDLE.
- Async reset mid-frame: tx_o returns to 1 immediately and the FSM goes to IDLE. The popped byte is lost; no frame_done_o pulse.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - Adds input ports parity_en_i (1 bit) and parity_odd_i (1 bit), both latched at frame start.
  - If parity_en_i=1, a PARITY state is inserted after DATA.
  - Parity bit value: XOR of the data bits when parity_odd_i=0 (even); inverted XOR when parity_odd_i=1 (odd).
  - If parity_en_i=0, PARITY is skipped.
- Not defined: parity ports and PARITY state are absent; frames are start+data+stop only.

Test Plan:
- Single byte 0xA5, baud_div_i=3, stop_bits_i=0, no parity:
  - Required: one fifo_rd_o pulse.
  - tx_o sequence, 4 clocks per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - frame_done_o 40 clocks after the start edge; busy_o then falls.
- Three queued bytes 0x00, 0xFF, 0x55, baud_div_i=0:
  - Required: three pops.
  - Frames separated by exactly 1 idle clock.
  - Correct LSB-first bit streams for all three bytes.
- stop_bits_i=1, byte 0x80, baud_div_i=1: stop high for 4 clocks. Changing stop_bits_i to 0 mid-frame has no effect.
- tx_en_i dropped during DATA of byte 0x3C with 0x11 still queued:
  - Required: 0x3C completes; no pop of 0x11 until tx_en_i returns to 1.
- rstn_i asserted during bit 3 of byte 0x0F: tx_o=1 and busy_o=0 asynchronously. After release, the next FIFO byte transmits cleanly.
- With UART_TX_PARITY_EN:
  - 0x07 with even parity gives parity bit 1.
  - 0x07 with odd parity gives parity bit 0.
  - 0x03 with even parity gives parity bit 0.
  - parity_en_i=0 gives frame length identical to the no-macro build.
